shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter DATA_W, default 64, operand/result width in bits.
REQ-002 Parameter AMT_W, default 6, shift-amount width; max shift = 2^AMT_W - 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only while ready=1.
REQ-006 in_data  input  DATA_W  unsigned operand, captured on accepted start.
REQ-007 shamt  input  AMT_W  unsigned left-shift amount, captured on accepted start.
REQ-008 ready  output  1  high in IDLE only.
REQ-009 busy  output  1  high in SHIFT or DONE.
REQ-010 done  output  1  one-cycle pulse, high only in DONE.
REQ-011 out_data  output  DATA_W  result register; holds last result until next DONE.
REQ-012 lost  output  1  result flag; 1 if any 1-bit was shifted out past the MSB, valid with out_data.

Function
REQ-013 The block SHALL compute out_data = (in_data << shamt) mod 2^DATA_W, zero-filled from the LSB, unsigned.
REQ-014 The block SHALL use one internal shift-by-2 step per SHIFT cycle (shift-by-1 only when the remaining count is 1); no barrel shifter.
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-016 IDLE: on start=1, capture in_data into acc, shamt into rem, clear lost-accumulator; next state SHIFT if shamt!=0, else DONE.
REQ-017 SHIFT, per edge: rem>=2 -> acc<<=2, rem-=2; rem==1 -> acc<<=1, rem=0; lost-accumulator ORed with the bits discarded that step.
REQ-018 SHIFT -> DONE on the edge where rem reaches 0; out_data and lost SHALL be loaded from acc/lost-accumulator on that same edge.
REQ-019 shamt=0 path: out_data<=in_data, lost<=0 loaded on the accept edge.
REQ-020 DONE SHALL last exactly one cycle, then IDLE unconditionally.
REQ-021 Latency: done SHALL be high in cycle ceil(shamt/2)+1 counted from the accept cycle (shamt=0 -> 1, 1 -> 2, 2 -> 2, 63 -> 33).
REQ-022 start while busy=1 SHALL be ignored with no effect on acc, rem or outputs; no queuing.
REQ-023 in_data/shamt changes after the accept edge SHALL NOT affect the in-flight result.
REQ-024 Back-to-back: start in the first IDLE cycle after DONE SHALL be accepted; minimum issue interval ceil(shamt/2)+2 cycles.
REQ-025 shamt >= DATA_W is unreachable at default widths; for non-default widths the result SHALL be 0 with lost = OR of all input bits.
REQ-026 ready, busy, done SHALL be decoded from state only (Moore); no combinational path from start.

Reset
REQ-027 reset=1 at a rising edge SHALL force IDLE, rem=0, acc=0, out_data=0, lost=0, done=0, from any state.
REQ-028 Reset mid-SHIFT SHALL abandon the operation; no done pulse for it.
REQ-029 Reset SHALL take priority over a simultaneous start.
REQ-030 First cycle after reset release: ready=1, busy=0, done=0.

Verification
REQ-031 Reset, then in_data=2, shamt=2 -> done in cycle 2, out_data=8, lost=0.
REQ-032 in_data=4, 8, 16 sequentially with shamt=2 -> out_data=16, 32, 64, each done in cycle 2; back-to-back accept right after DONE.
REQ-033 in_data=0x1, shamt=63 -> done in cycle 33, out_data=0x8000_0000_0000_0000, lost=0; shamt=0 with in_data=0xABCD -> done in cycle 1, out_data=0xABCD.
REQ-034 in_data=0xC000_0000_0000_0001, shamt=3 -> done in cycle 3, out_data=0x0000_0000_0000_0008, lost=1.
REQ-035 start pulsed every cycle during a shamt=9 operation with varying in_data -> single done in cycle 6, result from the first operand only.
REQ-036 reset asserted during cycle 3 of a shamt=20 operation -> no done, all outputs 0 next cycle, ready=1.

Source files
------------

// File: rtl/shift_sequencer.sv
// Sequential left shifter: advances two bit positions per cycle (one on an odd
// final step) and reports whether any set bit was pushed past the MSB.
module shift_sequencer #(
  parameter int DATA_W = 64,
  parameter int AMT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  shamt,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out_data,
  output logic              lost,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_acc;
  logic [AMT_W-1:0]    r_rem;
  logic                r_lost_acc;
  logic [DATA_W-1:0]   r_out;
  logic                r_lost;

  logic                w_step2;
  logic [DATA_W-1:0]   w_next_acc;
  logic [AMT_W-1:0]    w_next_rem;
  logic                w_drop;

  // One shift step: two positions while at least two remain, else one.
  assign w_step2    = (r_rem > AMT_W'(1));
  assign w_next_acc = w_step2 ? (r_acc << 2) : (r_acc << 1);
  assign w_next_rem = w_step2 ? (r_rem - AMT_W'(2)) : '0;
  assign w_drop     = w_step2 ? (|r_acc[DATA_W-1 -: 2]) : r_acc[DATA_W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_rem      <= '0;
      r_lost_acc <= 1'b0;
      r_out      <= '0;
      r_lost     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc      <= in_data;
            r_rem      <= shamt;
            r_lost_acc <= 1'b0;
            if (shamt == '0) begin
              r_out   <= in_data;
              r_lost  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_acc      <= w_next_acc;
          r_rem      <= w_next_rem;
          r_lost_acc <= r_lost_acc | w_drop;
          if (w_next_rem == '0) begin
            r_out   <= w_next_acc;
            r_lost  <= r_lost_acc | w_drop;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake: start is taken on a rising edge only while ready=1 (IDLE);
  // done pulses for exactly one cycle with out_data/lost already valid, and
  // start seen while busy=1 is dropped, not queued.
  assign ready     = (r_state == S_IDLE);
  assign busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign done      = (r_state == S_DONE);
  assign out_data  = r_out;
  assign lost      = r_lost;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed vector table, reset corner cases and
// randomized operations checked against a wide-arithmetic reference model.
module tb_shift_sequencer;
  localparam int DW = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] in_data;
  logic [AW-1:0] shamt;
  logic          ready, busy, done, lost;
  logic [DW-1:0] out_data;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [DW:0] exp_q[$];

  shift_sequencer #(.DATA_W(DW), .AMT_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .shamt(shamt),
    .ready(ready), .busy(busy), .done(done), .out_data(out_data), .lost(lost),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] s;
    bit            spam;
    logic [DW-1:0] exp_out;
    logic          exp_lost;
    int            exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%h expected=0x%h", name, got, exp);
    end
  endtask

  // Reference: shift in a double-width space, the upper half is what was lost.
  function automatic logic [DW:0] model(input logic [DW-1:0] d, input int sh);
    logic [2*DW-1:0] full;
    full = {{DW{1'b0}}, d} << sh;
    return {|full[2*DW-1:DW], full[DW-1:0]};
  endfunction

  task automatic run_op(input logic [DW-1:0] d, input logic [AW-1:0] s, input bit spam,
                        output int lat, output int waits);
    logic [DW:0] e;
    logic [DW:0] got;
    bit seen;
    bit bad;
    waits = 0;
    got = '0;
    @(negedge clk);
    while (!ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    start = 1'b1; in_data = d; shamt = s;
    exp_q.push_back(model(d, int'(s)));
    @(posedge clk); #1;
    start = spam;
    in_data = {$urandom, $urandom};
    shamt = AW'($urandom);
    lat = 0; seen = 1'b0; bad = 1'b0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      if (done) begin
        seen = 1'b1; lat = c; start = 1'b0;
        got = {lost, out_data};
        if (ready || !busy) bad = 1'b1;
      end else begin
        if (ready || !busy) bad = 1'b1;
        @(posedge clk); #1;
        if (spam) in_data = {$urandom, $urandom};
      end
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check("done_seen", DW'(seen), DW'(1));
    check("busy_while_running", DW'(bad), DW'(0));
    if (seen) begin
      check("out_data", got[DW-1:0], e[DW-1:0]);
      check("lost", DW'(got[DW]), DW'(e[DW]));
      @(posedge clk); #1;
      check("done_one_cycle", DW'({done, ready, busy}), DW'(3'b010));
    end
  endtask

  initial begin
    int lat, waits, s;
    logic [DW-1:0] d;
    bit spam;

    vecs[0] = '{64'd2, 6'd2, 1'b0, 64'd8, 1'b0, 2};
    vecs[1] = '{64'd4, 6'd2, 1'b0, 64'd16, 1'b0, 2};
    vecs[2] = '{64'd8, 6'd2, 1'b0, 64'd32, 1'b0, 2};
    vecs[3] = '{64'd16, 6'd2, 1'b0, 64'd64, 1'b0, 2};
    vecs[4] = '{64'h1, 6'd63, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 33};
    vecs[5] = '{64'hABCD, 6'd0, 1'b0, 64'hABCD, 1'b0, 1};
    vecs[6] = '{64'hC000_0000_0000_0001, 6'd3, 1'b0, 64'h8, 1'b1, 3};
    vecs[7] = '{64'h1234_5678_9ABC_DEF0, 6'd9, 1'b1, 64'h68AC_F135_79BD_E000, 1'b1, 6};
    vecs[8] = '{64'h8000_0000_0000_0000, 6'd1, 1'b0, 64'h0, 1'b1, 2};
    vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 33};

    reset = 1'b1; start = 1'b0; in_data = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", DW'({ready, busy, done, lost}), DW'(4'b1000));
    check("reset_out", out_data, '0);
    check("reset_state", DW'(dbg_state), DW'(0));
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].d, vecs[i].s, vecs[i].spam, lat, waits);
      check($sformatf("vec%0d_out_model", i), vecs[i].exp_out, model(vecs[i].d, int'(vecs[i].s)) & {DW{1'b1}});
      check($sformatf("vec%0d_latency", i), DW'(lat), DW'(vecs[i].exp_lat));
      check($sformatf("vec%0d_accept_first_idle", i), DW'(waits), DW'(0));
      check($sformatf("vec%0d_held_out", i), out_data, vecs[i].exp_out);
      check($sformatf("vec%0d_held_lost", i), DW'(lost), DW'(vecs[i].exp_lost));
    end

    // Reset wins over a simultaneous start.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; in_data = 64'h7; shamt = 6'd0;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check("reset_vs_start_flags", DW'({ready, busy, done}), DW'(3'b100));
    check("reset_vs_start_out", out_data, '0);
    @(posedge clk); #1;
    check("reset_vs_start_no_done", DW'(done), DW'(0));

    // Leave a nonzero result, then abandon a long shift with reset in cycle 3.
    run_op(64'h5, 6'd4, 1'b0, lat, waits);
    @(negedge clk);
    start = 1'b1; in_data = 64'hF0F0; shamt = 6'd20;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_flags", DW'({ready, busy, done, lost}), DW'(4'b1000));
    check("midreset_out", out_data, '0);
    begin
      bit any_done;
      any_done = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        if (done) any_done = 1'b1;
      end
      check("midreset_no_done", DW'(any_done), DW'(0));
    end

    for (int i = 0; i < 40; i++) begin
      d = {$urandom, $urandom};
      if (i % 5 == 0) d = d >> $urandom_range(0, 63);
      s = $urandom_range(0, 63);
      spam = ($urandom_range(0, 3) == 0);
      run_op(d, AW'(s), spam, lat, waits);
      check($sformatf("rand%0d_latency", i), DW'(lat), DW'((s + 1) / 2 + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
